// File: rtl/arp_scheduler.sv
// Arpeggiator / voice scheduler: sequences held-key slots into one note plus gate,
// with a one-TICK retrigger gap at the start of every step.
module arp_scheduler #(
    parameter int PRESCALE = 48,
    parameter int NOTE_W   = 7
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              TICK,
    input  logic [3:0]        KEY,
    input  logic [NOTE_W-1:0] FREQ0,
    input  logic [NOTE_W-1:0] FREQ1,
    input  logic [NOTE_W-1:0] FREQ2,
    input  logic [NOTE_W-1:0] FREQ3,
    input  logic              ARP_EN,
    input  logic [15:0]       ARP_TIME,
    input  logic              PingPongEn,
    output logic [NOTE_W-1:0] NOTE,
    output logic              GATE,
    output logic [1:0]        SLOT,
    output logic              STEP_STROBE
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    logic [1:0]        state;
    logic              dir_up;
    logic [PW-1:0]     pre_cnt;
    logic [15:0]       unit_cnt;

    logic [1:0]        low_slot;
    logic [1:0]        adv_slot;
    logic              adv_dir;
    logic [2:0]        fwd_hit;
    logic [2:0]        rev_hit;
    logic [NOTE_W-1:0] low_freq;
    logic [NOTE_W-1:0] adv_freq;
    logic [NOTE_W-1:0] cur_freq;
    logic [15:0]       step_units;
    logic              pre_wrap;
    logic              expire;

    function automatic logic [1:0] lowest_held(input logic [3:0] k);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (k[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Nearest held slot strictly above (up=1) or below (up=0) s; bit 2 flags a hit.
    function automatic logic [2:0] search(input logic [3:0] k, input logic [1:0] s,
                                          input logic up);
        logic [2:0] r;
        r = {1'b0, s};
        if (up) begin
            for (int i = 3; i >= 0; i--) begin
                if (k[i] && (i > int'(s))) r = {1'b1, 2'(i)};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (k[i] && (i < int'(s))) r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [NOTE_W-1:0] pick(input logic [1:0] s,
                                               input logic [NOTE_W-1:0] f0,
                                               input logic [NOTE_W-1:0] f1,
                                               input logic [NOTE_W-1:0] f2,
                                               input logic [NOTE_W-1:0] f3);
        logic [NOTE_W-1:0] r;
        case (s)
            2'd0:    r = f0;
            2'd1:    r = f1;
            2'd2:    r = f2;
            default: r = f3;
        endcase
        return r;
    endfunction

    always_comb begin
        low_slot = lowest_held(KEY);
        fwd_hit  = search(KEY, SLOT, PingPongEn ? dir_up : 1'b1);
        rev_hit  = search(KEY, SLOT, PingPongEn ? ~dir_up : 1'b0);
        adv_slot = SLOT;
        adv_dir  = 1'b1;
        if (!PingPongEn) begin
            adv_slot = fwd_hit[2] ? fwd_hit[1:0] : low_slot;
        end else if (fwd_hit[2]) begin
            adv_slot = fwd_hit[1:0];
            adv_dir  = dir_up;
        end else if (rev_hit[2]) begin
            adv_slot = rev_hit[1:0];
            adv_dir  = ~dir_up;
        end else begin
            adv_dir  = dir_up;
        end
        low_freq   = pick(low_slot, FREQ0, FREQ1, FREQ2, FREQ3);
        adv_freq   = pick(adv_slot, FREQ0, FREQ1, FREQ2, FREQ3);
        cur_freq   = pick(SLOT, FREQ0, FREQ1, FREQ2, FREQ3);
        step_units = (ARP_TIME == 16'd0) ? 16'd1 : ARP_TIME;
        pre_wrap   = (pre_cnt == PRE_LAST);
        // ARP_TIME is compared live, so a shortened step ends at the next unit wrap.
        expire     = pre_wrap && (({1'b0, unit_cnt} + 17'd1) >= {1'b0, step_units});
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            dir_up      <= 1'b1;
            pre_cnt     <= '0;
            unit_cnt    <= '0;
            NOTE        <= '0;
            GATE        <= 1'b0;
            SLOT        <= 2'd0;
            STEP_STROBE <= 1'b0;
        end else begin
            STEP_STROBE <= 1'b0;
            if (!ARP_EN) begin
                state <= ST_IDLE;
                GATE  <= |KEY;
                if (|KEY) begin
                    SLOT <= low_slot;
                    NOTE <= low_freq;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        GATE <= 1'b0;
                        if (|KEY) begin
                            SLOT        <= low_slot;
                            NOTE        <= low_freq;
                            STEP_STROBE <= 1'b1;
                            pre_cnt     <= '0;
                            unit_cnt    <= '0;
                            dir_up      <= 1'b1;
                            state       <= ST_GAP;
                        end
                    end
                    ST_GAP, ST_PLAY: begin
                        if (KEY == 4'd0) begin
                            state <= ST_IDLE;
                            GATE  <= 1'b0;
                        end else if (!KEY[SLOT] || (TICK && expire)) begin
                            // Release of the sounding slot wins over a coincident TICK.
                            SLOT        <= adv_slot;
                            NOTE        <= adv_freq;
                            dir_up      <= adv_dir;
                            STEP_STROBE <= 1'b1;
                            pre_cnt     <= '0;
                            unit_cnt    <= '0;
                            GATE        <= 1'b0;
                            state       <= ST_GAP;
                        end else begin
                            NOTE <= cur_freq;
                            if (TICK) begin
                                if (pre_wrap) begin
                                    pre_cnt  <= '0;
                                    unit_cnt <= unit_cnt + 16'd1;
                                end else begin
                                    pre_cnt  <= pre_cnt + PW'(1);
                                end
                                if (state == ST_GAP) begin
                                    state <= ST_PLAY;
                                    GATE  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        GATE  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arp_scheduler.sv
// Scoreboard bench for arp_scheduler: expected slot/note per step is queued when a run
// is configured and consumed on every STEP_STROBE, alongside step-length and gap checks.
module tb_arp_scheduler;

    localparam int PRESCALE = 2;
    localparam int NOTE_W   = 7;

    typedef struct {
        int slot;
        int note;
    } exp_t;

    logic              CLK;
    logic              RESET_N;
    logic              TICK;
    logic [3:0]        KEY;
    logic [NOTE_W-1:0] FREQ0, FREQ1, FREQ2, FREQ3;
    logic              ARP_EN;
    logic [15:0]       ARP_TIME;
    logic              PingPongEn;
    logic [NOTE_W-1:0] NOTE;
    logic              GATE;
    logic [1:0]        SLOT;
    logic              STEP_STROBE;

    logic [NOTE_W-1:0] freq_tb [4];
    exp_t              sb [$];
    int                checks;
    int                failures;
    bit                mon_en;
    bit                armed;
    int                ticks_since;
    int                exp_len;
    int                tick_phase;

    assign FREQ0 = freq_tb[0];
    assign FREQ1 = freq_tb[1];
    assign FREQ2 = freq_tb[2];
    assign FREQ3 = freq_tb[3];

    arp_scheduler #(.PRESCALE(PRESCALE), .NOTE_W(NOTE_W)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .TICK        (TICK),
        .KEY         (KEY),
        .FREQ0       (FREQ0),
        .FREQ1       (FREQ1),
        .FREQ2       (FREQ2),
        .FREQ3       (FREQ3),
        .ARP_EN      (ARP_EN),
        .ARP_TIME    (ARP_TIME),
        .PingPongEn  (PingPongEn),
        .NOTE        (NOTE),
        .GATE        (GATE),
        .SLOT        (SLOT),
        .STEP_STROBE (STEP_STROBE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Expected step order from the held-slot list: cyclic in up mode, bouncing in ping-pong.
    task automatic push_seq(input logic [3:0] k, input bit pp, input int n);
        int   held [$];
        int   per, pos, idx;
        exp_t e;
        for (int i = 0; i < 4; i++) if (k[i]) held.push_back(i);
        for (int s = 0; s < n; s++) begin
            if (!pp || held.size() == 1) begin
                idx = s % held.size();
            end else begin
                per = 2 * (held.size() - 1);
                pos = s % per;
                idx = (pos < held.size()) ? pos : per - pos;
            end
            e.slot = held[idx];
            e.note = int'(freq_tb[held[idx]]);
            sb.push_back(e);
        end
    endtask

    task automatic run_seq(input logic [3:0] k, input bit pp, input logic [15:0] at,
                           input int n);
        mon_en = 1'b0;
        ARP_EN = 1'b0;
        KEY    = 4'd0;
        repeat (3) step();
        ARP_TIME   = at;
        PingPongEn = pp;
        exp_len    = ((at == 16'd0) ? 1 : int'(at)) * PRESCALE;
        push_seq(k, pp, n);
        mon_en = 1'b1;
        KEY    = k;
        ARP_EN = 1'b1;
        for (int i = 0; i < 3000 && sb.size() != 0; i++) step();
        chk("sb_drain", sb.size(), 0);
        sb.delete();
        mon_en = 1'b0;
    endtask

    // TICK generation and output monitor share one negedge thread so TICK is counted
    // exactly as the DUT consumed it at the preceding rising edge.
    initial begin
        exp_t e;
        TICK        = 1'b0;
        tick_phase  = 0;
        armed       = 1'b0;
        ticks_since = 0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (TICK) ticks_since++;
                if (STEP_STROBE) begin
                    if (armed) chk("step_len", ticks_since, exp_len);
                    armed       = 1'b1;
                    ticks_since = 0;
                    chk("sb_pending", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("slot", int'(SLOT), e.slot);
                        chk("note", int'(NOTE), e.note);
                    end
                end
                if (armed) chk("gap_gate", int'(GATE), (ticks_since == 0) ? 0 : 1);
            end else begin
                armed       = 1'b0;
                ticks_since = 0;
            end
            tick_phase = (tick_phase + 1) % 4;
            TICK       = (tick_phase == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        RESET_N    = 1'b0;
        KEY        = 4'd0;
        ARP_EN     = 1'b0;
        ARP_TIME   = 16'd0;
        PingPongEn = 1'b0;
        for (int i = 0; i < 4; i++) freq_tb[i] = '0;

        // Reset
        repeat (3) step();
        chk("rst_note", int'(NOTE), 0);
        chk("rst_gate", int'(GATE), 0);
        RESET_N = 1'b1;
        repeat (2) step();
        chk("rst_note_post", int'(NOTE), 0);
        chk("rst_gate_post", int'(GATE), 0);
        chk("rst_slot_post", int'(SLOT), 0);
        chk("rst_strobe_post", int'(STEP_STROBE), 0);

        // Bypass
        freq_tb[0] = 7'd48; freq_tb[1] = 7'd60; freq_tb[2] = 7'd64; freq_tb[3] = 7'd55;
        KEY = 4'b0110;
        #1;
        chk("byp_latency_note", int'(NOTE), 0);
        step();
        chk("byp_note", int'(NOTE), 60);
        chk("byp_slot", int'(SLOT), 1);
        chk("byp_gate", int'(GATE), 1);
        chk("byp_strobe", int'(STEP_STROBE), 0);
        KEY = 4'd0;
        step();
        chk("byp_rel_gate", int'(GATE), 0);
        chk("byp_rel_note", int'(NOTE), 60);
        chk("byp_rel_slot", int'(SLOT), 1);

        // Up mode, ping-pong, ARP_TIME=0
        freq_tb[1] = 7'd52;
        run_seq(4'b1011, 1'b0, 16'd3, 6);
        run_seq(4'b0111, 1'b1, 16'd1, 7);
        run_seq(4'b1011, 1'b0, 16'd0, 4);

        // Release of the sounding slot mid-step
        repeat (3) step();
        ARP_TIME   = 16'd3;
        PingPongEn = 1'b0;
        KEY        = 4'b0011;
        ARP_EN     = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            found = (SLOT == 2'd1) && STEP_STROBE;
        end
        chk("rel_reach_slot1", int'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = GATE;
        end
        chk("rel_gate_on", int'(found), 1);
        KEY = 4'b0001;
        step();
        chk("rel_slot", int'(SLOT), 0);
        chk("rel_strobe", int'(STEP_STROBE), 1);
        chk("rel_gate", int'(GATE), 0);
        chk("rel_note", int'(NOTE), 48);
        KEY = 4'd0;
        step();
        chk("idle_gate", int'(GATE), 0);
        chk("idle_strobe", int'(STEP_STROBE), 0);
        repeat (10) step();
        chk("idle_gate_hold", int'(GATE), 0);
        chk("idle_slot_hold", int'(SLOT), 0);
        chk("idle_note_hold", int'(NOTE), 48);

        // Asynchronous reset mid-PLAY
        KEY = 4'b0011;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            found = GATE && (SLOT == 2'd1);
        end
        chk("arst_play_reached", int'(found), 1);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("arst_note", int'(NOTE), 0);
        chk("arst_gate", int'(GATE), 0);
        chk("arst_slot", int'(SLOT), 0);
        chk("arst_strobe", int'(STEP_STROBE), 0);
        step();
        RESET_N = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
